// File: rtl/cordic_mag_avg.sv
// cordic_mag_avg
// Block averager for the unsigned magnitude stream produced by the pipelined
// CORDIC magnitude unit. The unit sums blocks of 2**LOG2_N samples and presents
// floor(sum / 2**LOG2_N) on a valid/ready port. Upstream cannot stall, so a
// result that finds the output still occupied is dropped and counted.
//
// Optional feature macro: CORDIC_MAG_PEAK_EN
//   defined   - per-block unsigned maximum is tracked and presented on peak_o
//   undefined - peak_o is tied to zero and no tracker logic is built
//
// WIDTH must equal Q_I+Q_F+1; LOG2_N is legal in the range 1..8.
module cordic_mag_avg #(
  parameter int Q_I    = 15,
  parameter int Q_F    = 16,
  parameter int WIDTH  = Q_I + Q_F + 1,
  parameter int LOG2_N = 4,
  parameter int DROP_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [WIDTH-1:0]  data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WIDTH-1:0]  mean_o,
  output logic [WIDTH-1:0]  peak_o,
  output logic              overrun_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  // The accumulator carries LOG2_N guard bits so a full block of all-ones
  // samples still fits without wrapping.
  localparam int ACC_W = WIDTH + LOG2_N;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [LOG2_N-1:0]   r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    w_acc_sum;
  logic [WIDTH-1:0]    r_mean;
  logic                r_overrun;
  logic [DROP_W-1:0]   r_drop_cnt;

  logic                w_sample;
  logic                w_complete;
  logic                w_accept;
  logic                w_load;
  logic                w_drop;

  // clear_i wins over a coincident sample, so a sample only counts without it.
  assign w_sample   = valid_i && !clear_i;
  assign w_complete = w_sample && (&r_cnt);
  assign w_accept   = (r_state == ST_FULL) && ready_i;

  // A finished block is stored if the holding register is free or is being
  // emptied in this very cycle (back-to-back delivery); otherwise it is lost.
  assign w_load     = w_complete && ((r_state == ST_EMPTY) || w_accept);
  assign w_drop     = w_complete && (r_state == ST_FULL) && !w_accept;

  // The completing sample is folded in combinationally so it is part of the
  // result without an extra pipeline stage.
  assign w_acc_sum  = r_acc + {{LOG2_N{1'b0}}, data_i};

  // Sample counter and accumulator; both restart after a completed block.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_sample) begin
      r_cnt <= r_cnt + LOG2_N'(1);
      if (w_complete) begin
        r_acc <= '0;
      end else begin
        r_acc <= w_acc_sum;
      end
    end
  end

  // Output FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Output FSM next-state: a completion keeps or makes the port FULL; an
  // acceptance without a new completion empties it.
  always_comb begin
    w_state_next = r_state;
    if (clear_i) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_complete) begin
            w_state_next = ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_accept && !w_complete) begin
            w_state_next = ST_EMPTY;
          end
        end
        default: begin
          w_state_next = ST_EMPTY;
        end
      endcase
    end
  end

  // Held mean: loaded only when a block result is accepted into the port, so
  // it stays stable while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mean <= '0;
    end else if (clear_i) begin
      r_mean <= '0;
    end else if (w_load) begin
      r_mean <= w_acc_sum[ACC_W-1:LOG2_N];
    end
  end

  // Overrun pulse: one cycle after a completion that found the port occupied.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_drop;
    end
  end

  // Saturating drop counter; deliberately survives clear_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {DROP_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + DROP_W'(1);
    end
  end

`ifdef CORDIC_MAG_PEAK_EN
  logic [WIDTH-1:0] r_peak_trk;
  logic [WIDTH-1:0] r_peak;
  logic [WIDTH-1:0] w_peak_max;

  // Running maximum including the current sample.
  assign w_peak_max = (data_i > r_peak_trk) ? data_i : r_peak_trk;

  // Per-block peak tracker; restarts after each completed block.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_peak_trk <= '0;
    end else if (clear_i) begin
      r_peak_trk <= '0;
    end else if (w_sample) begin
      if (w_complete) begin
        r_peak_trk <= '0;
      end else begin
        r_peak_trk <= w_peak_max;
      end
    end
  end

  // Held peak follows exactly the same load/clear rules as the held mean.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_peak <= '0;
    end else if (clear_i) begin
      r_peak <= '0;
    end else if (w_load) begin
      r_peak <= w_peak_max;
    end
  end

  assign peak_o = r_peak;
`else
  assign peak_o = '0;
`endif

  assign valid_o    = (r_state == ST_FULL);
  assign mean_o     = r_mean;
  assign overrun_o  = r_overrun;
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_cordic_mag_avg.sv
// Directed and scoreboarded bench for cordic_mag_avg with LOG2_N=2.
module tb_cordic_mag_avg;

  localparam int W  = 32;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          valid_in;
  logic [W-1:0]  data_in;
  logic          valid_out;
  logic          ready;
  logic [W-1:0]  mean_out;
  logic [W-1:0]  peak_out;
  logic          overrun_out;
  logic [DW-1:0] drop_cnt_out;

  int n_vec = 0;
  int n_err = 0;

  cordic_mag_avg #(
    .Q_I(15), .Q_F(16), .WIDTH(W), .LOG2_N(2), .DROP_W(DW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear),
    .valid_i    (valid_in),
    .data_i     (data_in),
    .valid_o    (valid_out),
    .ready_i    (ready),
    .mean_o     (mean_out),
    .peak_o     (peak_out),
    .overrun_o  (overrun_out),
    .drop_cnt_o (drop_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected peak_o depends on whether the peak feature is compiled in.
  function automatic logic [W-1:0] pk(input logic [W-1:0] p);
`ifdef CORDIC_MAG_PEAK_EN
    return p;
`else
    return '0 & p;
`endif
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the clock edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic c);
    valid_in = v;
    data_in  = d;
    ready    = r;
    clear    = c;
    @(posedge clk);
    #1;
    $display("cyc v=%0b d=%08h r=%0b c=%0b -> vo=%0b mean=%08h peak=%08h ovr=%0b drop=%0d",
             v, d, r, c, valid_out, mean_out, peak_out, overrun_out, drop_cnt_out);
  endtask

  // Scoreboard model state for the random phase.
  int           m_cnt;
  logic [63:0]  m_sum;
  logic [W-1:0] m_trk;
  logic         m_full;
  logic [W-1:0] m_mean;
  logic [W-1:0] m_peak;
  int           m_drop;
  int           n_compl;
  int           n_deliv;
  int           n_lost;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; valid_in = 1'b0; data_in = '0; ready = 1'b0;

    // Reset state, with valid_i pulsing during reset (must be ignored).
    step(1'b1, 32'hFFFF0000, 1'b0, 1'b0);
    step(1'b1, 32'hFFFF0000, 1'b0, 1'b0);
    check_val("rst_valid", valid_out, 0);
    check_val("rst_mean", mean_out, 0);
    check_val("rst_peak", peak_out, 0);
    check_val("rst_ovr", overrun_out, 0);
    check_val("rst_drop", drop_cnt_out, 0);
    rst_n = 1'b1;

    // Basic block mean.
    step(1'b1, 32'h00010000, 1'b1, 1'b0);
    step(1'b1, 32'h00020000, 1'b1, 1'b0);
    step(1'b1, 32'h00030000, 1'b1, 1'b0);
    check_val("b1_not_yet", valid_out, 0);
    step(1'b1, 32'h00040000, 1'b1, 1'b0);
    check_val("b1_valid", valid_out, 1);
    check_val("b1_mean", mean_out, 32'h00028000);
    check_val("b1_peak", peak_out, pk(32'h00040000));
    check_val("b1_ovr", overrun_out, 0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_val("b1_taken", valid_out, 0);

    // Truncation: 5/4 -> 1.
    step(1'b1, 32'h1, 1'b1, 1'b0);
    step(1'b1, 32'h1, 1'b1, 1'b0);
    step(1'b1, 32'h1, 1'b1, 1'b0);
    step(1'b1, 32'h2, 1'b1, 1'b0);
    check_val("trunc_mean", mean_out, 32'h1);
    check_val("trunc_peak", peak_out, pk(32'h2));
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Full-scale samples: accumulator must not overflow.
    for (int i = 0; i < 4; i++) step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    check_val("max_mean", mean_out, 32'hFFFFFFFF);
    check_val("max_peak", peak_out, pk(32'hFFFFFFFF));
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Stalled consumer: three blocks, two overruns, first result held.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h00010000, 1'b0, 1'b0);
    check_val("st_valid", valid_out, 1);
    check_val("st_mean1", mean_out, 32'h00010000);
    check_val("st_ovr0", overrun_out, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h00020000, 1'b0, 1'b0);
    check_val("st_ovr1", overrun_out, 1);
    check_val("st_drop1", drop_cnt_out, 1);
    check_val("st_hold1", mean_out, 32'h00010000);
    step(1'b1, 32'h00030000, 1'b0, 1'b0);
    check_val("st_ovr_pulse", overrun_out, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h00030000, 1'b0, 1'b0);
    check_val("st_ovr2", overrun_out, 1);
    check_val("st_drop2", drop_cnt_out, 2);
    check_val("st_hold2", mean_out, 32'h00010000);
    check_val("st_hold_peak", peak_out, pk(32'h00010000));
    check_val("st_still_valid", valid_out, 1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_val("st_taken", valid_out, 0);
    check_val("st_ovr_end", overrun_out, 0);

    // Completion coinciding with acceptance: back-to-back, no overrun.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h00050000, 1'b0, 1'b0);
    check_val("bb_first", mean_out, 32'h00050000);
    step(1'b1, 32'h00010000, 1'b0, 1'b0);
    step(1'b1, 32'h00020000, 1'b0, 1'b0);
    step(1'b1, 32'h00030000, 1'b0, 1'b0);
    step(1'b1, 32'h00060000, 1'b1, 1'b0);
    check_val("bb_valid", valid_out, 1);
    check_val("bb_mean", mean_out, 32'h00030000);
    check_val("bb_peak", peak_out, pk(32'h00060000));
    check_val("bb_ovr", overrun_out, 0);
    check_val("bb_drop", drop_cnt_out, 2);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_val("bb_taken", valid_out, 0);

    // clear_i with a coincident sample discards the partial block.
    step(1'b1, 32'h00010000, 1'b1, 1'b0);
    step(1'b1, 32'h00010000, 1'b1, 1'b0);
    step(1'b1, 32'h00010000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h00040000, 1'b1, 1'b0);
      check_val("clr_no_early", valid_out, 0);
    end
    step(1'b1, 32'h00040000, 1'b0, 1'b0);
    check_val("clr_valid", valid_out, 1);
    check_val("clr_mean", mean_out, 32'h00040000);
    check_val("clr_peak", peak_out, pk(32'h00040000));
    step(1'b0, 32'h0, 1'b0, 1'b1);
    check_val("clr_full", valid_out, 0);
    check_val("clr_keep_drop", drop_cnt_out, 2);

    // Asynchronous reset with valid_o=1 and a partial block in flight.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h00070000, 1'b0, 1'b0);
    step(1'b1, 32'h00010000, 1'b0, 1'b0);
    step(1'b1, 32'h00010000, 1'b0, 1'b0);
    valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", valid_out, 0);
    check_val("arst_mean", mean_out, 0);
    check_val("arst_peak", peak_out, 0);
    check_val("arst_ovr", overrun_out, 0);
    check_val("arst_drop", drop_cnt_out, 0);
    step(1'b1, 32'hFFFF0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 32'h00080000, 1'b1, 1'b0);
    check_val("arst_new_mean", mean_out, 32'h00080000);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_val("arst_taken", valid_out, 0);

    // Random valid/ready with a scoreboard model.
    m_cnt = 0; m_sum = 0; m_trk = 0; m_full = 0; m_mean = 0; m_peak = 0; m_drop = 0;
    n_compl = 0; n_deliv = 0; n_lost = 0;
    for (int c = 0; c < 300; c++) begin
      logic         v, r, comp, acc, ovr_exp;
      logic [W-1:0] d, mx;
      logic [63:0]  s;
      v = (($urandom % 4) != 0);
      r = (($urandom % 4) == 0);
      d = ($urandom % 2 == 0) ? $urandom : ($urandom % 32'h00100000);
      comp = v && (m_cnt == 3);
      acc  = m_full && r;
      s    = m_sum + {32'h0, d};
      mx   = (d > m_trk) ? d : m_trk;
      ovr_exp = 1'b0;
      if (comp) begin
        n_compl++;
        if (!m_full || acc) begin
          if (acc) n_deliv++;
          m_mean = s[W+1:2];
          m_peak = mx;
          m_full = 1'b1;
        end else begin
          ovr_exp = 1'b1;
          n_lost++;
          if (m_drop < 255) m_drop++;
        end
      end else if (acc) begin
        n_deliv++;
        m_full = 1'b0;
      end
      if (v) begin
        m_cnt = (m_cnt + 1) % 4;
        m_sum = comp ? 64'h0 : s;
        m_trk = comp ? '0 : mx;
      end
      step(v, d, r, 1'b0);
      check_val("rnd_valid", valid_out, m_full);
      check_val("rnd_ovr", overrun_out, ovr_exp);
      check_val("rnd_drop", drop_cnt_out, m_drop);
      if (m_full) begin
        check_val("rnd_mean", mean_out, m_mean);
        check_val("rnd_peak", peak_out, pk(m_peak));
      end
    end
    if (m_full) n_deliv++;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_val("rnd_drained", valid_out, 0);
    check_val("rnd_accounting", n_deliv + n_lost, n_compl);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
